// File: rtl/pipe_io_unit_if.sv
// ---------------------------------------------------------------------------
// pipe_io_unit_if
// MEM-stage data bus as seen by the memory-mapped I/O peripheral.
//   we      store strobe (mwmem)
//   addr    byte address (malu)
//   wdata   store data (mb)
//   rdata   load data returned to the MEM/WB path
//   io_sel  address falls inside the I/O window
// master: pipeline side (drives we/addr/wdata)
// slave : peripheral side (drives rdata/io_sel)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface pipe_io_unit_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        io_sel;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  io_sel
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output io_sel
    );
endinterface

// File: rtl/pipe_io_unit.sv
// ---------------------------------------------------------------------------
// pipe_io_unit
// Memory-mapped I/O peripheral sitting beside the data RAM in the MEM stage.
// A 16-byte window at IO_BASE holds four word registers:
//   off 0  SW    RO  debounced switches, zero-extended
//   off 1  HEX   RW  six hex digits in bits [23:0]
//   off 2  CNT   RO  free-running 32-bit cycle counter
//   off 3  CTRL  RW  bit0 RUN, bit1 CLR (write-one, reads 0), bit2 CHG (W1C)
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   bus          slave side of the MEM-stage data bus
//   sw           raw asynchronous switch inputs
//   hex0..hex5   hex digit outputs, hexN = HEX[4N+3:4N]
// Reads are purely combinational so pipeline stalls and replays cannot
// disturb any state.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_io_unit #(
    parameter logic [31:0] IO_BASE  = 32'h0000_0080,
    parameter int          DEBOUNCE = 4,
    parameter int          SW_W     = 10
) (
    input  logic             clock,
    input  logic             reset,
    pipe_io_unit_if.slave    bus,
    input  logic [SW_W-1:0]  sw,
    output logic [3:0]       hex0,
    output logic [3:0]       hex1,
    output logic [3:0]       hex2,
    output logic [3:0]       hex3,
    output logic [3:0]       hex4,
    output logic [3:0]       hex5
);

    // Elaboration-time sanity on parameters.
    if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
        $error("pipe_io_unit: DEBOUNCE must be 1..255");
    end
    if (SW_W < 1 || SW_W > 16) begin : g_bad_sw_w
        $error("pipe_io_unit: SW_W must be 1..16");
    end
    if (IO_BASE[3:0] != 4'h0) begin : g_bad_base
        $error("pipe_io_unit: IO_BASE must be 16-byte aligned");
    end

    localparam logic [1:0] OFF_SW   = 2'd0;
    localparam logic [1:0] OFF_HEX  = 2'd1;
    localparam logic [1:0] OFF_CNT  = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    localparam logic [7:0] DC_LAST = 8'(DEBOUNCE - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [1:0] off;
    logic       sel;
    logic       wr_hex;
    logic       wr_ctrl;

    assign sel     = (bus.addr[31:4] == IO_BASE[31:4]);
    assign off     = bus.addr[3:2];
    assign wr_hex  = bus.we && sel && (off == OFF_HEX);
    assign wr_ctrl = bus.we && sel && (off == OFF_CTRL);

    assign bus.io_sel = sel;

    // Byte offset bits and the top store byte have no destination.
    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:24]};

    // ------------------------------------------------------------------
    // Switch path: two-flop synchroniser followed by a consecutive-cycle
    // debounce counter. Any cycle where the synchronised value matches the
    // held value restarts the count, so a bounce back mid-count is lost.
    // ------------------------------------------------------------------
    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;
    logic [SW_W-1:0] sw_db;
    logic [7:0]      dc;
    logic            db_done;

    assign db_done = (sw_s2 != sw_db) && (dc == DC_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_db <= '0;
            dc    <= '0;
        end else if (sw_s2 == sw_db) begin
            dc <= '0;
        end else if (db_done) begin
            sw_db <= sw_s2;
            dc    <= '0;
        end else begin
            dc <= dc + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // HEX display register
    // ------------------------------------------------------------------
    logic [23:0] hex_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hex_r <= '0;
        end else if (wr_hex) begin
            hex_r <= bus.wdata[23:0];
        end
    end

    assign hex0 = hex_r[3:0];
    assign hex1 = hex_r[7:4];
    assign hex2 = hex_r[11:8];
    assign hex3 = hex_r[15:12];
    assign hex4 = hex_r[19:16];
    assign hex5 = hex_r[23:20];

    // ------------------------------------------------------------------
    // CTRL: RUN is a plain RW bit. CHG is set by a debounce update and
    // cleared by writing 1; if both happen on one edge the set wins so a
    // switch change is never silently dropped.
    // ------------------------------------------------------------------
    logic run;
    logic chg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run <= 1'b1;
        end else if (wr_ctrl) begin
            run <= bus.wdata[0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chg <= 1'b0;
        end else if (db_done) begin
            chg <= 1'b1;
        end else if (wr_ctrl && bus.wdata[2]) begin
            chg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter. Increments on the registered RUN value; a CLR write
    // takes precedence over the increment on that edge. Wraps silently.
    // ------------------------------------------------------------------
    logic [31:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (wr_ctrl && bus.wdata[1]) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux: zero outside the window.
    // ------------------------------------------------------------------
    always_comb begin
        bus.rdata = '0;
        if (sel) begin
            case (off)
                OFF_SW:   bus.rdata[SW_W-1:0] = sw_db;
                OFF_HEX:  bus.rdata[23:0]     = hex_r;
                OFF_CNT:  bus.rdata           = cnt;
                OFF_CTRL: bus.rdata[2:0]      = {chg, 1'b0, run};
                default:  bus.rdata           = '0;
            endcase
        end
    end

endmodule
